// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the BCD stopwatch digit chain.
// Latency: combinational helpers only, evaluated at elaboration or in comb logic.
// Backpressure: none; pure functions.
package stopwatch_pkg;

  localparam int BASE10 = 10;
  localparam int BASE6  = 6;
  localparam int MAX_ND = 7;  // 3 fraction + 2 seconds + 2 minute digits

  // Base of digit idx in the LSB-first layout; only seconds-tens is base 6.
  function automatic int digit_base(input int idx, input int frac_digits);
    return (idx == frac_digits + 1) ? BASE6 : BASE10;
  endfunction

  // Limit one BCD digit to the largest value its base allows.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input int base);
    logic [3:0] top;
    top = 4'(base - 1);
    return (d > top) ? top : d;
  endfunction

  // Largest representable count: every digit at its base maximum.
  function automatic logic [4*MAX_ND-1:0] max_value(input int nd, input int frac_digits);
    logic [4*MAX_ND-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_ND; i++) begin
      if (i < nd) v[4*i +: 4] = 4'(digit_base(i, frac_digits) - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One up/down BCD digit of configurable base with clear, load and terminal count.
// Latency: digit updates one clock after en/load/clear.
// Backpressure: none; the enable chain decides when the digit steps.
module bcd_digit_counter import stopwatch_pkg::*; #(
  parameter int BASE = BASE10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       carry_out
);

  localparam logic [3:0] TOP = 4'(BASE - 1);

  // Terminal count: carry when at TOP counting up, borrow when at 0 counting down.
  assign carry_out = up ? (digit == TOP) : (digit == 4'd0);

  // Digit register: clear beats load beats count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   digit <= '0;
    else if (clear) digit <= '0;
    else if (load)  digit <= load_val;
    else if (en) begin
      if (up) digit <= carry_out ? 4'd0 : digit + 4'd1;
      else    digit <= carry_out ? TOP  : digit - 4'd1;
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// BCD min:sec.frac stopwatch/countdown on an internal tick enable, with lap freeze.
// Latency: a tick in cycle N shows on time_bcd in cycle N+1; disp_bcd is a comb mux.
// Backpressure: none; control inputs are single-cycle pulses acted on immediately.
module lap_stopwatch import stopwatch_pkg::*; #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int FRAC_DIGITS = 1,
  parameter int MIN_DIGITS  = 1,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start_stop_p,
  input  logic                                        clear_p,
  input  logic                                        lap_p,
  input  logic                                        mode_down,
  input  logic [4*(FRAC_DIGITS+2+MIN_DIGITS)-1:0]     preset,
  output logic [4*(FRAC_DIGITS+2+MIN_DIGITS)-1:0]     time_bcd,
  output logic [4*(FRAC_DIGITS+2+MIN_DIGITS)-1:0]     disp_bcd,
  output logic                                        running,
  output logic                                        lap_active,
  output logic                                        done,
  output logic                                        overflow
);

  localparam int ND  = FRAC_DIGITS + 2 + MIN_DIGITS;
  localparam int DIV = CLK_HZ / (10 ** FRAC_DIGITS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [4*MAX_ND-1:0] MAX_FULL = max_value(ND, FRAC_DIGITS);
  localparam logic [4*ND-1:0]     MAXV     = MAX_FULL[4*ND-1:0];
  localparam logic [4*ND-1:0]     ONE      = 1;

  logic [DW-1:0]   div_q;
  logic            running_q, lap_active_q, done_q, overflow_q, dir_down;
  logic [4*ND-1:0] lap_q;
  logic [4*ND-1:0] load_val;
  logic [ND-1:0]   tc;
  logic [ND:0]     chain;
  logic            tick, at_max, at_zero, sat_hit, zero_hit, step, ss_ok;

  assign tick     = running_q && (div_q == DW'(DIV - 1));
  assign at_max   = (time_bcd == MAXV);
  assign at_zero  = (time_bcd == '0);
  // Saturating up-count at the top holds the digits instead of wrapping.
  assign sat_hit  = tick && !dir_down && at_max && SATURATE;
  // Countdown: the tick leaving 1 lands on zero and ends the run.
  assign zero_hit = tick && dir_down && (time_bcd == ONE);
  assign step     = tick && !sat_hit && !(dir_down && at_zero);
  assign ss_ok    = start_stop_p && !(dir_down && at_zero) && !(done_q && SATURATE);

  assign chain[0] = step;

  for (genvar i = 0; i < ND; i++) begin : g_digit
    localparam int B = digit_base(i, FRAC_DIGITS);
    assign load_val[4*i +: 4] = clamp_digit(preset[4*i +: 4], B);
    bcd_digit_counter #(.BASE(B)) u_digit (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (chain[i]),
      .up        (!dir_down),
      .load      (clear_p && mode_down),
      .load_val  (load_val[4*i +: 4]),
      .clear     (clear_p && !mode_down),
      .digit     (time_bcd[4*i +: 4]),
      .carry_out (tc[i])
    );
    assign chain[i+1] = chain[i] && tc[i];
  end

  // Tick divider: advances only while running so a stop keeps sub-tick phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       div_q <= '0;
    else if (clear_p)   div_q <= '0;
    else if (running_q) div_q <= (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);
  end

  // Run state, sticky done, direction and wrap pulse; terminal events beat start/stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      dir_down   <= 1'b0;
    end else if (clear_p) begin
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      dir_down   <= mode_down;
    end else begin
      // Carry out of the top digit while counting up means the count wrapped.
      overflow_q <= !dir_down && chain[ND];
      if (sat_hit || zero_hit) begin
        running_q <= 1'b0;
        done_q    <= 1'b1;
      end else if (ss_ok) begin
        running_q <= !running_q;
      end
    end
  end

  // Lap freeze: capture the pre-update count on entry, release on the next pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_active_q <= 1'b0;
      lap_q        <= '0;
    end else if (clear_p) begin
      lap_active_q <= 1'b0;
    end else if (lap_p) begin
      if (!lap_active_q) lap_q <= time_bcd;
      lap_active_q <= !lap_active_q;
    end
  end

  assign disp_bcd   = lap_active_q ? lap_q : time_bcd;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench: one slow stopwatch (DIV=100) and two fast ones (DIV=1, wrap and saturate).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; pulses are driven one cycle wide.
module tb_lap_stopwatch;

  localparam int NI   = 3;
  localparam int MAXU = 5999;  // 9:59.9 expressed in tenths of a second

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_stop_p = 1'b0;
  logic        clear_p = 1'b0;
  logic        lap_p = 1'b0;
  logic        mode_down = 1'b0;
  logic [15:0] preset = '0;

  logic [15:0] time_bcd [NI];
  logic [15:0] disp_bcd [NI];
  logic        running [NI];
  logic        lap_active [NI];
  logic        done [NI];
  logic        overflow [NI];

  int checks = 0;
  int failures = 0;

  // Reference state per instance, in whole tenths rather than digits.
  int m_t [NI];
  int m_dv [NI];
  int m_lapv [NI];
  bit m_run [NI];
  bit m_lapa [NI];
  bit m_done [NI];
  bit m_dn [NI];
  bit m_ovf [NI];

  always #5 clk = ~clk;

  lap_stopwatch #(.CLK_HZ(1000), .FRAC_DIGITS(1), .MIN_DIGITS(1), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .start_stop_p(start_stop_p), .clear_p(clear_p), .lap_p(lap_p),
    .mode_down(mode_down), .preset(preset), .time_bcd(time_bcd[0]), .disp_bcd(disp_bcd[0]),
    .running(running[0]), .lap_active(lap_active[0]), .done(done[0]), .overflow(overflow[0]));

  lap_stopwatch #(.CLK_HZ(10), .FRAC_DIGITS(1), .MIN_DIGITS(1), .SATURATE(1'b0)) u1 (
    .clk(clk), .reset_n(reset_n), .start_stop_p(start_stop_p), .clear_p(clear_p), .lap_p(lap_p),
    .mode_down(mode_down), .preset(preset), .time_bcd(time_bcd[1]), .disp_bcd(disp_bcd[1]),
    .running(running[1]), .lap_active(lap_active[1]), .done(done[1]), .overflow(overflow[1]));

  lap_stopwatch #(.CLK_HZ(10), .FRAC_DIGITS(1), .MIN_DIGITS(1), .SATURATE(1'b1)) u2 (
    .clk(clk), .reset_n(reset_n), .start_stop_p(start_stop_p), .clear_p(clear_p), .lap_p(lap_p),
    .mode_down(mode_down), .preset(preset), .time_bcd(time_bcd[2]), .disp_bcd(disp_bcd[2]),
    .running(running[2]), .lap_active(lap_active[2]), .done(done[2]), .overflow(overflow[2]));

  function automatic int div_of(input int k);
    return (k == 0) ? 100 : 1;
  endfunction

  function automatic bit sat_of(input int k);
    return (k == 2);
  endfunction

  function automatic logic [15:0] to_bcd(input int u);
    logic [15:0] r;
    int s;
    s = (u / 10) % 60;
    r[3:0]   = 4'(u % 10);
    r[7:4]   = 4'(s % 10);
    r[11:8]  = 4'(s / 10);
    r[15:12] = 4'(u / 600);
    return r;
  endfunction

  function automatic int preset_units(input logic [15:0] p);
    int d0, d1, d2, d3;
    d0 = (p[3:0] > 9) ? 9 : int'(p[3:0]);
    d1 = (p[7:4] > 9) ? 9 : int'(p[7:4]);
    d2 = (p[11:8] > 5) ? 5 : int'(p[11:8]);
    d3 = (p[15:12] > 9) ? 9 : int'(p[15:12]);
    return d3 * 600 + d2 * 100 + d1 * 10 + d0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_t[k] = 0; m_dv[k] = 0; m_lapv[k] = 0;
      m_run[k] = 0; m_lapa[k] = 0; m_done[k] = 0; m_dn[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // Apply one clock of the stopwatch rules to every reference instance.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit tick, term;
      tick = m_run[k] && (m_dv[k] == div_of(k) - 1);
      m_ovf[k] = 0;
      if (clear_p) begin
        m_t[k] = mode_down ? preset_units(preset) : 0;
        m_dv[k] = 0; m_run[k] = 0; m_lapa[k] = 0; m_done[k] = 0; m_dn[k] = mode_down;
      end else begin
        int old_t;
        old_t = m_t[k];
        term = 0;
        if (m_run[k]) m_dv[k] = tick ? 0 : m_dv[k] + 1;
        if (tick) begin
          if (!m_dn[k]) begin
            if (old_t == MAXU) begin
              if (sat_of(k)) term = 1;
              else begin m_t[k] = 0; m_ovf[k] = 1; end
            end else m_t[k] = old_t + 1;
          end else if (old_t > 0) begin
            m_t[k] = old_t - 1;
            if (old_t == 1) term = 1;
          end
        end
        if (term) begin
          m_run[k] = 0; m_done[k] = 1;
        end else if (start_stop_p && !(m_dn[k] && old_t == 0) && !(m_done[k] && sat_of(k))) begin
          m_run[k] = !m_run[k];
        end
        if (lap_p) begin
          if (!m_lapa[k]) begin m_lapa[k] = 1; m_lapv[k] = old_t; end
          else m_lapa[k] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_stop_p = 1'b1; cycle(); start_stop_p = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_p = 1'b1; cycle(); clear_p = 1'b0;
  endtask

  task automatic pulse_lap();
    lap_p = 1'b1; cycle(); lap_p = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #12;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (time_bcd[k] !== 16'h0 || disp_bcd[k] !== 16'h0 || running[k] !== 1'b0 ||
          lap_active[k] !== 1'b0 || done[k] !== 1'b0 || overflow[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state inst%0d: time=%h disp=%h run=%b lap=%b done=%b ovf=%b, want all 0",
                 k, time_bcd[k], disp_bcd[k], running[k], lap_active[k], done[k], overflow[k]);
      end
    end
    reset_n = 1'b1;
    cycle();
    pulse_start();
    repeat (100) cycle();
    checks++;
    if (time_bcd[0] !== 16'h0001) begin
      failures++; $display("FAIL first_tick: time=%h want 0001", time_bcd[0]);
    end
    checks++;
    if (running[0] !== 1'b1) begin
      failures++; $display("FAIL first_tick_running: running=%b want 1", running[0]);
    end
    repeat (30) cycle();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (time_bcd[k] !== 16'h0 || disp_bcd[k] !== 16'h0 || running[k] !== 1'b0 ||
          lap_active[k] !== 1'b0 || done[k] !== 1'b0 || overflow[k] !== 1'b0) begin
        failures++;
        $display("FAIL async_reset inst%0d: time=%h disp=%h run=%b lap=%b done=%b ovf=%b, want all 0",
                 k, time_bcd[k], disp_bcd[k], running[k], lap_active[k], done[k], overflow[k]);
      end
    end
    #2 reset_n = 1'b1;
  endtask

  task automatic test_up_carry();
    int n;
    mode_down = 1'b0;
    pulse_clear();
    pulse_start();
    repeat (599) cycle();
    checks++;
    if (time_bcd[1] !== 16'h0599) begin
      failures++; $display("FAIL carry_599: time=%h want 0599", time_bcd[1]);
    end
    cycle();
    checks++;
    if (time_bcd[1] !== 16'h1000) begin
      failures++; $display("FAIL carry_minute: time=%h want 1000", time_bcd[1]);
    end
    repeat (37) cycle();
    pulse_start();  // stop on the 638th edge since start: divider phase 38, count 6
    checks++;
    if (running[0] !== 1'b0 || time_bcd[0] !== 16'h0006) begin
      failures++; $display("FAIL stop: run=%b time=%h want 0 0006", running[0], time_bcd[0]);
    end
    repeat (250) cycle();
    checks++;
    if (time_bcd[0] !== 16'h0006) begin
      failures++; $display("FAIL stopped_hold: time=%h want 0006", time_bcd[0]);
    end
    pulse_start();
    n = 0;
    while (time_bcd[0] === 16'h0006 && n < 200) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 62 || time_bcd[0] !== 16'h0007) begin
      failures++; $display("FAIL restart_phase: cycles=%0d time=%h want 62 0007", n, time_bcd[0]);
    end
  endtask

  task automatic test_wrap_sat();
    mode_down = 1'b0;
    pulse_clear();
    pulse_start();
    repeat (5999) cycle();
    checks++;
    if (time_bcd[1] !== 16'h9599 || time_bcd[2] !== 16'h9599) begin
      failures++; $display("FAIL reach_max: wrap=%h sat=%h want 9599", time_bcd[1], time_bcd[2]);
    end
    cycle();
    checks++;
    if (time_bcd[1] !== 16'h0000 || overflow[1] !== 1'b1 || running[1] !== 1'b1) begin
      failures++;
      $display("FAIL wrap: time=%h ovf=%b run=%b want 0000 1 1", time_bcd[1], overflow[1], running[1]);
    end
    checks++;
    if (time_bcd[2] !== 16'h9599 || running[2] !== 1'b0 || done[2] !== 1'b1 || overflow[2] !== 1'b0) begin
      failures++;
      $display("FAIL saturate: time=%h run=%b done=%b ovf=%b want 9599 0 1 0",
               time_bcd[2], running[2], done[2], overflow[2]);
    end
    cycle();
    checks++;
    if (overflow[1] !== 1'b0) begin
      failures++; $display("FAIL overflow_width: ovf=%b want 0", overflow[1]);
    end
    pulse_start();
    checks++;
    if (running[2] !== 1'b0 || done[2] !== 1'b1 || time_bcd[2] !== 16'h9599) begin
      failures++;
      $display("FAIL sat_start_ignored: run=%b done=%b time=%h want 0 1 9599", running[2], done[2], time_bcd[2]);
    end
  endtask

  task automatic test_countdown();
    mode_down = 1'b1; preset = 16'h0003;
    pulse_clear();
    mode_down = 1'b0;
    pulse_start();
    repeat (299) cycle();
    checks++;
    if (time_bcd[0] !== 16'h0001 || running[0] !== 1'b1) begin
      failures++; $display("FAIL down_pre_zero: time=%h run=%b want 0001 1", time_bcd[0], running[0]);
    end
    cycle();
    checks++;
    if (time_bcd[0] !== 16'h0000 || done[0] !== 1'b1 || running[0] !== 1'b0) begin
      failures++;
      $display("FAIL down_zero: time=%h done=%b run=%b want 0000 1 0", time_bcd[0], done[0], running[0]);
    end
    pulse_start();
    checks++;
    if (running[0] !== 1'b0) begin
      failures++; $display("FAIL down_start_ignored: run=%b want 0", running[0]);
    end
    mode_down = 1'b1; preset = 16'h1000;
    pulse_clear();
    mode_down = 1'b0;
    pulse_start();
    repeat (100) cycle();
    checks++;
    if (time_bcd[0] !== 16'h0599) begin
      failures++; $display("FAIL down_borrow: time=%h want 0599", time_bcd[0]);
    end
    mode_down = 1'b1; preset = 16'h0A7C;
    pulse_clear();
    mode_down = 1'b0;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (time_bcd[k] !== 16'h0579) begin
        failures++; $display("FAIL preset_clamp inst%0d: time=%h want 0579", k, time_bcd[k]);
      end
    end
  endtask

  task automatic test_lap();
    mode_down = 1'b0;
    pulse_clear();
    pulse_start();
    repeat (1200) cycle();
    pulse_lap();
    checks++;
    if (disp_bcd[0] !== 16'h0012 || lap_active[0] !== 1'b1) begin
      failures++; $display("FAIL lap_capture: disp=%h lap=%b want 0012 1", disp_bcd[0], lap_active[0]);
    end
    repeat (799) cycle();
    checks++;
    if (time_bcd[0] !== 16'h0020 || disp_bcd[0] !== 16'h0012) begin
      failures++; $display("FAIL lap_frozen: time=%h disp=%h want 0020 0012", time_bcd[0], disp_bcd[0]);
    end
    pulse_lap();
    checks++;
    if (disp_bcd[0] !== 16'h0020 || lap_active[0] !== 1'b0) begin
      failures++; $display("FAIL lap_release: disp=%h lap=%b want 0020 0", disp_bcd[0], lap_active[0]);
    end
  endtask

  task automatic test_clear_collision();
    mode_down = 1'b0;
    pulse_clear();
    pulse_start();
    repeat (49) cycle();
    pulse_lap();
    repeat (49) cycle();
    checks++;
    if (lap_active[0] !== 1'b1) begin
      failures++; $display("FAIL collision_setup: lap=%b want 1", lap_active[0]);
    end
    clear_p = 1'b1; start_stop_p = 1'b1; lap_p = 1'b1;
    cycle();  // the 100th edge since start is also a tick
    clear_p = 1'b0; start_stop_p = 1'b0; lap_p = 1'b0;
    checks++;
    if (time_bcd[0] !== 16'h0 || running[0] !== 1'b0 || lap_active[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++;
      $display("FAIL clear_dominates: time=%h run=%b lap=%b done=%b want 0 0 0 0",
               time_bcd[0], running[0], lap_active[0], done[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      start_stop_p = ($urandom_range(0, 39) == 0);
      clear_p      = ($urandom_range(0, 149) == 0);
      lap_p        = ($urandom_range(0, 59) == 0);
      mode_down    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) preset = 16'($urandom);
      cycle();
      for (int k = 0; k < NI; k++) begin
        logic [15:0] exp_disp;
        exp_disp = m_lapa[k] ? to_bcd(m_lapv[k]) : to_bcd(m_t[k]);
        checks++;
        if (time_bcd[k] !== to_bcd(m_t[k])) begin
          failures++; $display("FAIL rnd_time c%0d inst%0d: got %h want %h", c, k, time_bcd[k], to_bcd(m_t[k]));
        end
        checks++;
        if (disp_bcd[k] !== exp_disp) begin
          failures++; $display("FAIL rnd_disp c%0d inst%0d: got %h want %h", c, k, disp_bcd[k], exp_disp);
        end
        checks++;
        if (running[k] !== m_run[k] || lap_active[k] !== m_lapa[k] ||
            done[k] !== m_done[k] || overflow[k] !== m_ovf[k]) begin
          failures++;
          $display("FAIL rnd_flags c%0d inst%0d: run/lap/done/ovf got %b%b%b%b want %b%b%b%b", c, k,
                   running[k], lap_active[k], done[k], overflow[k], m_run[k], m_lapa[k], m_done[k], m_ovf[k]);
        end
      end
    end
    start_stop_p = 1'b0; clear_p = 1'b0; lap_p = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_wrap_sat();
    test_countdown();
    test_lap();
    test_clear_collision();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
